qea_run_ctrl: RTL and testbench

- Host-side sequencer directly upstream of QEA; owns all QEA host ports.
- Accepts a job config and a valid/ready stream of gate-context words, then writes them into QEA context RAM.
- Initialises QEA state RAM to |0…0>, pulses start, waits for completion with a timeout, then reads the final state vector back as a valid/ready result stream.
- Replaces hand-written bench sequencing with a reusable, synthesizable controller.

---
 rtl/qea_pkg.sv | 45 ++++
 rtl/qea_run_ctrl_if.sv | 55 +++++
 rtl/qea_run_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_qea_run_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qea_pkg.sv
// Shared types and constants for the QEA host-side run controller.
// Widths match the QEA core defaults; ONE_FIXED is 1.0 in the core's fixed-point format.
package qea_pkg;

    localparam int PE_NUM_WIDTH            = 2;
    localparam int PE_NUM                  = 4;
    localparam int DATA_WIDTH              = 32;
    localparam int MAX_QBIT_WIDTH          = 6;
    localparam int STATE_DATA_WIDTH        = 64;
    localparam int STATE_ADDR_WIDTH        = 16;
    localparam int GATE_CONTEXT_DATA_WIDTH = 64;
    localparam int GATE_CONTEXT_ADDR_WIDTH = 16;
    localparam int NUM_FRAC_BIT            = 30;

    localparam int ROW_WIDTH = PE_NUM * STATE_DATA_WIDTH;
    localparam int AMP_TOP   = ROW_WIDTH - 1;

    localparam logic [DATA_WIDTH-1:0]       ONE_FIXED = DATA_WIDTH'(1'b1) << NUM_FRAC_BIT;
    // Amplitude layout is {real, imag}; |0...0> has real = 1.0, imag = 0.
    localparam logic [STATE_DATA_WIDTH-1:0] AMP_ONE   = {ONE_FIXED, {DATA_WIDTH{1'b0}}};

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD_CTX   = 4'd1,
        ST_INIT_STATE = 4'd2,
        ST_INIT_GAP   = 4'd3,
        ST_START      = 4'd4,
        ST_RUN        = 4'd5,
        ST_READ_ISSUE = 4'd6,
        ST_READ_WAIT  = 4'd7,
        ST_READ_OUT   = 4'd8
    } run_state_e;

    function automatic logic [ROW_WIDTH-1:0] init_row(input logic is_row0);
        logic [ROW_WIDTH-1:0] row_s;
        row_s = '0;
        if (is_row0) begin
            row_s[AMP_TOP -: STATE_DATA_WIDTH] = AMP_ONE;
        end else begin
            row_s = '0;
        end
        return row_s;
    endfunction

endpackage

// File: rtl/qea_run_ctrl_if.sv
// Host-side bus of the QEA run controller: job/context/result streams and all QEA host ports.
interface qea_run_ctrl_if;
    import qea_pkg::*;

    logic                                 i_cfg_valid;
    logic                                 o_cfg_ready;
    logic [MAX_QBIT_WIDTH-1:0]            i_cfg_qbit_num;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_cfg_ins_num;
    logic                                 i_ctx_valid;
    logic                                 o_ctx_ready;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data;
    logic                                 o_qea_start;
    logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num;
    logic                                 o_qea_ctx_en;
    logic                                 o_qea_ctx_wea;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data;
    logic                                 o_qea_state_ena;
    logic                                 o_qea_state_wea;
    logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra;
    logic [ROW_WIDTH-1:0]                 o_qea_state_dina;
    logic                                 i_qea_complete;
    logic [ROW_WIDTH-1:0]                 i_qea_state_dout;
    logic                                 o_res_valid;
    logic                                 i_res_ready;
    logic [ROW_WIDTH-1:0]                 o_res_data;
    logic [STATE_ADDR_WIDTH-1:0]          o_res_addr;
    logic                                 o_res_last;
    logic                                 o_busy;
    logic                                 o_done;
    logic                                 o_err_cfg;
    logic                                 o_err_timeout;
    logic [31:0]                          o_cycle_count;

    modport master (
        input  i_cfg_valid, i_cfg_qbit_num, i_cfg_ins_num, i_ctx_valid, i_ctx_data,
               i_qea_complete, i_qea_state_dout, i_res_ready,
        output o_cfg_ready, o_ctx_ready, o_qea_start, o_qea_qbit_num, o_qea_ctx_en,
               o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena,
               o_qea_state_wea, o_qea_state_addra, o_qea_state_dina, o_res_valid,
               o_res_data, o_res_addr, o_res_last, o_busy, o_done, o_err_cfg,
               o_err_timeout, o_cycle_count
    );

    modport slave (
        output i_cfg_valid, i_cfg_qbit_num, i_cfg_ins_num, i_ctx_valid, i_ctx_data,
               i_qea_complete, i_qea_state_dout, i_res_ready,
        input  o_cfg_ready, o_ctx_ready, o_qea_start, o_qea_qbit_num, o_qea_ctx_en,
               o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena,
               o_qea_state_wea, o_qea_state_addra, o_qea_state_dina, o_res_valid,
               o_res_data, o_res_addr, o_res_last, o_busy, o_done, o_err_cfg,
               o_err_timeout, o_cycle_count
    );

endinterface

// File: rtl/qea_run_ctrl.sv
// Job sequencer in front of QEA: loads context, initialises |0...0>, starts the core,
// times the run and streams the final state vector back out row by row.
module qea_run_ctrl
    import qea_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic            clk,
    input logic            rst,
    qea_run_ctrl_if.master bus
);

    localparam int                ROWS_W      = STATE_ADDR_WIDTH + 1;
    localparam logic [7:0]        WAIT_LAST   = 8'(READ_LATENCY - 1);
    localparam logic [31:0]       TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

    run_state_e                           state_r;
    logic [MAX_QBIT_WIDTH-1:0]            qbit_r;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_last_r;
    logic [STATE_ADDR_WIDTH-1:0]          last_row_r;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   word_idx_r;
    logic [STATE_ADDR_WIDTH-1:0]          row_r;
    logic [7:0]                           wait_r;
    logic [31:0]                          cycle_r;

    logic                                 cfg_ready_r;
    logic                                 ctx_ready_r;
    logic                                 busy_r;
    logic                                 start_r;
    logic                                 done_r;
    logic                                 err_cfg_r;
    logic                                 err_timeout_r;
    logic                                 ctx_en_r;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_r;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_r;
    logic                                 state_ena_r;
    logic                                 state_wea_r;
    logic [STATE_ADDR_WIDTH-1:0]          state_addr_r;
    logic [ROW_WIDTH-1:0]                 state_dina_r;
    logic                                 res_valid_r;
    logic [ROW_WIDTH-1:0]                 res_data_r;
    logic [STATE_ADDR_WIDTH-1:0]          res_addr_r;
    logic                                 res_last_r;

    logic                                 cfg_ok_s;
    logic [MAX_QBIT_WIDTH-1:0]            row_shift_s;
    logic [ROWS_W-1:0]                    row_cnt_s;
    logic [ROWS_W-1:0]                    row_max_s;

    // Config validation and row-count derivation for the incoming job request.
    always_comb begin
        row_shift_s = bus.i_cfg_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
        row_cnt_s   = ROWS_W'(1'b1) << row_shift_s;
        row_max_s   = row_cnt_s - ROWS_W'(1'b1);
        if (bus.i_cfg_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) begin
            cfg_ok_s = 1'b0;
        end else if (row_shift_s > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH)) begin
            cfg_ok_s = 1'b0;
        end else if (bus.i_cfg_ins_num == '0) begin
            cfg_ok_s = 1'b0;
        end else begin
            cfg_ok_s = 1'b1;
        end
    end

    // Job FSM; every output is a register updated on the transition that needs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            qbit_r        <= '0;
            ins_last_r    <= '0;
            last_row_r    <= '0;
            word_idx_r    <= '0;
            row_r         <= '0;
            wait_r        <= 8'd0;
            cycle_r       <= 32'd0;
            cfg_ready_r   <= 1'b1;
            ctx_ready_r   <= 1'b0;
            busy_r        <= 1'b0;
            start_r       <= 1'b0;
            done_r        <= 1'b0;
            err_cfg_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            ctx_en_r      <= 1'b0;
            ctx_addr_r    <= '0;
            ctx_data_r    <= '0;
            state_ena_r   <= 1'b0;
            state_wea_r   <= 1'b0;
            state_addr_r  <= '0;
            state_dina_r  <= '0;
            res_valid_r   <= 1'b0;
            res_data_r    <= '0;
            res_addr_r    <= '0;
            res_last_r    <= 1'b0;
        end else begin
            start_r       <= 1'b0;
            done_r        <= 1'b0;
            err_cfg_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            ctx_en_r      <= 1'b0;
            state_ena_r   <= 1'b0;
            state_wea_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_cfg_valid && cfg_ready_r) begin
                        if (cfg_ok_s) begin
                            qbit_r      <= bus.i_cfg_qbit_num;
                            ins_last_r  <= bus.i_cfg_ins_num - GATE_CONTEXT_ADDR_WIDTH'(1'b1);
                            last_row_r  <= row_max_s[STATE_ADDR_WIDTH-1:0];
                            word_idx_r  <= '0;
                            cfg_ready_r <= 1'b0;
                            ctx_ready_r <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= ST_LOAD_CTX;
                        end else begin
                            err_cfg_r   <= 1'b1;
                        end
                    end
                end
                ST_LOAD_CTX: begin
                    if (bus.i_ctx_valid && ctx_ready_r) begin
                        ctx_en_r   <= 1'b1;
                        ctx_addr_r <= word_idx_r;
                        ctx_data_r <= bus.i_ctx_data;
                        word_idx_r <= word_idx_r + GATE_CONTEXT_ADDR_WIDTH'(1'b1);
                        if (word_idx_r == ins_last_r) begin
                            ctx_ready_r <= 1'b0;
                            row_r       <= '0;
                            state_r     <= ST_INIT_STATE;
                        end
                    end
                end
                ST_INIT_STATE: begin
                    state_ena_r  <= 1'b1;
                    state_wea_r  <= 1'b1;
                    state_addr_r <= row_r;
                    state_dina_r <= init_row(row_r == '0);
                    row_r        <= row_r + STATE_ADDR_WIDTH'(1'b1);
                    if (row_r == last_row_r) begin
                        state_r <= ST_INIT_GAP;
                    end
                end
                ST_INIT_GAP: begin
                    state_r <= ST_START;
                end
                ST_START: begin
                    start_r <= 1'b1;
                    cycle_r <= 32'd0;
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    // cycle_r equals the number of cycles since start, so the first two are masked.
                    if (bus.i_qea_complete && (cycle_r >= 32'd2)) begin
                        row_r        <= '0;
                        state_ena_r  <= 1'b1;
                        state_addr_r <= '0;
                        state_r      <= ST_READ_ISSUE;
                    end else begin
                        cycle_r <= cycle_r + 32'd1;
                        if ((cycle_r + 32'd1) == TIMEOUT_VAL) begin
                            err_timeout_r <= 1'b1;
                            done_r        <= 1'b1;
                            cfg_ready_r   <= 1'b1;
                            busy_r        <= 1'b0;
                            state_r       <= ST_IDLE;
                        end
                    end
                end
                ST_READ_ISSUE: begin
                    wait_r  <= 8'd0;
                    state_r <= ST_READ_WAIT;
                end
                ST_READ_WAIT: begin
                    if (wait_r == WAIT_LAST) begin
                        res_valid_r <= 1'b1;
                        res_data_r  <= bus.i_qea_state_dout;
                        res_addr_r  <= row_r;
                        res_last_r  <= (row_r == last_row_r);
                        state_r     <= ST_READ_OUT;
                    end else begin
                        wait_r <= wait_r + 8'd1;
                    end
                end
                ST_READ_OUT: begin
                    if (bus.i_res_ready) begin
                        res_valid_r <= 1'b0;
                        if (row_r == last_row_r) begin
                            done_r      <= 1'b1;
                            cfg_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else begin
                            row_r        <= row_r + STATE_ADDR_WIDTH'(1'b1);
                            state_ena_r  <= 1'b1;
                            state_addr_r <= row_r + STATE_ADDR_WIDTH'(1'b1);
                            state_r      <= ST_READ_ISSUE;
                        end
                    end
                end
                default: begin
                    cfg_ready_r <= 1'b1;
                    ctx_ready_r <= 1'b0;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_cfg_ready       = cfg_ready_r;
    assign bus.o_ctx_ready       = ctx_ready_r;
    assign bus.o_qea_start       = start_r;
    assign bus.o_qea_qbit_num    = qbit_r;
    assign bus.o_qea_ctx_en      = ctx_en_r;
    assign bus.o_qea_ctx_wea     = ctx_en_r;
    assign bus.o_qea_ctx_addr    = ctx_addr_r;
    assign bus.o_qea_ctx_data    = ctx_data_r;
    assign bus.o_qea_state_ena   = state_ena_r;
    assign bus.o_qea_state_wea   = state_wea_r;
    assign bus.o_qea_state_addra = state_addr_r;
    assign bus.o_qea_state_dina  = state_dina_r;
    assign bus.o_res_valid       = res_valid_r;
    assign bus.o_res_data        = res_data_r;
    assign bus.o_res_addr        = res_addr_r;
    assign bus.o_res_last        = res_last_r;
    assign bus.o_busy            = busy_r;
    assign bus.o_done            = done_r;
    assign bus.o_err_cfg         = err_cfg_r;
    assign bus.o_err_timeout     = err_timeout_r;
    assign bus.o_cycle_count     = cycle_r;

endmodule

// File: tb/tb_qea_run_ctrl.sv
// Directed-plus-random bench for qea_run_ctrl with a stub QEA and a queue-based reference model.
module tb_qea_run_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qea_run_ctrl_if bus();

    qea_run_ctrl #(.READ_LATENCY(1), .TIMEOUT_CYCLES(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0, start_cnt = 0, done_cnt = 0, ena_cnt = 0, ctx_wea_bad = 0;
    logic [15:0]  ctx_addr_q[$];
    logic [63:0]  ctx_data_q[$];
    logic [15:0]  ini_addr_q[$];
    logic [255:0] ini_data_q[$];
    logic [63:0]  exp_ctx[$];
    logic [255:0] res_mem [4];
    logic [255:0] exp_row0;

    // Observer: records every QEA-side strobe as seen mid-cycle.
    always @(negedge clk) begin
        if (bus.o_qea_ctx_en === 1'b1) begin
            ctx_addr_q.push_back(bus.o_qea_ctx_addr);
            ctx_data_q.push_back(bus.o_qea_ctx_data);
            if (bus.o_qea_ctx_wea !== 1'b1) ctx_wea_bad++;
        end
        if (bus.o_qea_state_ena === 1'b1) begin
            ena_cnt++;
            if (bus.o_qea_state_wea === 1'b1) begin
                ini_addr_q.push_back(bus.o_qea_state_addra);
                ini_data_q.push_back(bus.o_qea_state_dina);
            end else begin
                rd_cnt++;
            end
        end
        if (bus.o_qea_start === 1'b1) start_cnt++;
        if (bus.o_done === 1'b1) done_cnt++;
    end

    // Stub state RAM read port: one-cycle latency, returns the bench's final-state rows.
    always @(posedge clk) begin
        if (bus.o_qea_state_ena === 1'b1 && bus.o_qea_state_wea === 1'b0)
            bus.i_qea_state_dout <= res_mem[bus.o_qea_state_addra[1:0]];
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_res();
        for (int r = 0; r < 4; r++)
            res_mem[r] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Accepts a job, streams its context, and returns at the negedge of the start cycle.
    task automatic load_job(input int qb, input int ins, input bit gaps);
        int sent, guard, bad, rows;
        logic hs;
        logic [255:0] exp_d;
        rows = 1 << (qb - 2);
        exp_ctx.delete(); ctx_addr_q.delete(); ctx_data_q.delete();
        ini_addr_q.delete(); ini_data_q.delete();
        rd_cnt = 0; start_cnt = 0; done_cnt = 0; ctx_wea_bad = 0;
        for (int i = 0; i < ins; i++) exp_ctx.push_back({$urandom, $urandom});
        bus.i_cfg_valid = 1'b1; bus.i_cfg_qbit_num = 6'(qb); bus.i_cfg_ins_num = 16'(ins);
        @(posedge clk); #1 bus.i_cfg_valid = 1'b0;
        chk("busy_after_cfg", bus.o_busy, 1'b1);
        chk("qbit_latch", bus.o_qea_qbit_num, qb);
        sent = 0; guard = 0;
        while (sent < ins && guard < 4 * ins + 20) begin
            bus.i_ctx_valid = gaps ? ((guard % 2) == 0) : 1'b1;
            bus.i_ctx_data  = exp_ctx[sent];
            @(negedge clk);
            hs = bus.i_ctx_valid && bus.o_ctx_ready;
            @(posedge clk); #1;
            if (hs) sent++;
            guard++;
        end
        bus.i_ctx_valid = 1'b0;
        chk("ctx_accepted", sent, ins);
        guard = 0;
        @(negedge clk);
        while (bus.o_qea_start !== 1'b1 && guard < 200 + 2 * rows) begin
            @(negedge clk);
            guard++;
        end
        chk("start_seen", bus.o_qea_start, 1'b1);
        chk("ctx_count", ctx_addr_q.size(), ins);
        bad = 0;
        for (int i = 0; i < ctx_addr_q.size() && i < ins; i++)
            if (ctx_addr_q[i] !== 16'(i) || ctx_data_q[i] !== exp_ctx[i]) bad++;
        chk("ctx_words_bad", bad, 0);
        chk("ctx_wea_bad", ctx_wea_bad, 0);
        chk("init_count", ini_addr_q.size(), rows);
        bad = 0;
        for (int i = 0; i < ini_addr_q.size(); i++) begin
            exp_d = (i == 0) ? exp_row0 : '0;
            if (ini_addr_q[i] !== 16'(i) || ini_data_q[i] !== exp_d) bad++;
        end
        chk("init_rows_bad", bad, 0);
        if (ini_data_q.size() > 0) chk("init_row0_top", ini_data_q[0][255:192], exp_row0[255:192]);
    endtask

    // Completes the run after cdelay cycles and drains all result rows.
    task automatic readback(input int rows, input int cdelay, input int stall_len);
        int guard, rd0;
        bit stable;
        logic [255:0] d0;
        logic [15:0] a0;
        repeat (cdelay) @(posedge clk);
        #1 bus.i_qea_complete = 1'b1;
        @(posedge clk); #1 bus.i_qea_complete = 1'b0;
        for (int b = 0; b < rows; b++) begin
            guard = 0;
            @(negedge clk);
            while (bus.o_res_valid !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("res_valid", bus.o_res_valid, 1'b1);
            chk("res_data", bus.o_res_data, res_mem[b]);
            chk("res_addr", bus.o_res_addr, b);
            chk("res_last", bus.o_res_last, (b == rows - 1));
            if (b == 0 && stall_len > 0) begin
                stable = 1'b1; d0 = bus.o_res_data; a0 = bus.o_res_addr; rd0 = rd_cnt;
                repeat (stall_len) begin
                    @(negedge clk);
                    if (bus.o_res_data !== d0 || bus.o_res_addr !== a0 || bus.o_res_valid !== 1'b1) stable = 1'b0;
                end
                chk("stall_stable", stable, 1'b1);
                chk("stall_no_reads", rd_cnt, rd0);
            end
            bus.i_res_ready = 1'b1;
            @(posedge clk); #1 bus.i_res_ready = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", bus.o_done, 1'b1);
        chk("cycle_count", bus.o_cycle_count, cdelay);
        chk("start_pulses", start_cnt, 1);
        chk("read_count", rd_cnt, rows);
        @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("cfg_ready_after", bus.o_cfg_ready, 1'b1);
    endtask

    initial begin
        int bad_q[3];
        int bad_i[3];
        int ena0, ctxw0, guard, qb;
        logic [255:0] one_v;
        one_v = 256'd1;
        exp_row0 = (one_v << 30) << 224;
        bad_q[0] = 1;  bad_i[0] = 5;
        bad_q[1] = 19; bad_i[1] = 5;
        bad_q[2] = 3;  bad_i[2] = 0;

        rst = 1'b1;
        bus.i_cfg_valid = 1'b0; bus.i_cfg_qbit_num = 6'd0; bus.i_cfg_ins_num = 16'd0;
        bus.i_ctx_valid = 1'b0; bus.i_ctx_data = 64'd0;
        bus.i_qea_complete = 1'b0; bus.i_res_ready = 1'b0;
        fill_res();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg_ready", bus.o_cfg_ready, 1'b1);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_ctx_ready", bus.o_ctx_ready, 1'b0);
        chk("rst_start", bus.o_qea_start, 1'b0);
        chk("rst_res_valid", bus.o_res_valid, 1'b0);
        chk("rst_cycle_count", bus.o_cycle_count, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        fill_res(); load_job(3, 85, 1'b0); readback(2, 40, 0);
        fill_res(); load_job(3, 85, 1'b1); readback(2, 40, 10);
        fill_res(); load_job(2, 1, 1'b0);  readback(1, $urandom_range(2, 30), 0);
        for (int j = 0; j < 3; j++) begin
            qb = $urandom_range(2, 4);
            fill_res();
            load_job(qb, $urandom_range(1, 20), $urandom_range(0, 1));
            readback(1 << (qb - 2), $urandom_range(2, 45), $urandom_range(0, 6));
        end

        for (int t = 0; t < 3; t++) begin
            ena0 = ena_cnt; ctxw0 = ctx_addr_q.size();
            bus.i_cfg_valid = 1'b1; bus.i_cfg_qbit_num = 6'(bad_q[t]); bus.i_cfg_ins_num = 16'(bad_i[t]);
            bus.i_ctx_valid = 1'b1;
            @(posedge clk); #1 bus.i_cfg_valid = 1'b0;
            @(negedge clk);
            chk("cfg_err_pulse", bus.o_err_cfg, 1'b1);
            chk("cfg_rej_ready", bus.o_cfg_ready, 1'b1);
            chk("ctx_not_acked", bus.o_ctx_ready, 1'b0);
            @(negedge clk);
            chk("cfg_err_once", bus.o_err_cfg, 1'b0);
            bus.i_ctx_valid = 1'b0;
            repeat (3) @(negedge clk);
            chk("rej_no_writes", ena_cnt + ctx_addr_q.size(), ena0 + ctxw0);
        end

        load_job(3, 7, 1'b0);
        repeat (49) @(negedge clk);
        chk("to_not_early", bus.o_err_timeout, 1'b0);
        @(negedge clk);
        chk("to_err", bus.o_err_timeout, 1'b1);
        chk("to_done", bus.o_done, 1'b1);
        chk("to_count", bus.o_cycle_count, 50);
        @(negedge clk);
        chk("to_cfg_ready", bus.o_cfg_ready, 1'b1);
        chk("to_err_once", bus.o_err_timeout, 1'b0);
        chk("to_no_read", rd_cnt, 0);

        @(posedge clk); #1;
        bus.i_cfg_valid = 1'b1; bus.i_cfg_qbit_num = 6'd6; bus.i_cfg_ins_num = 16'd3;
        @(posedge clk); #1 bus.i_cfg_valid = 1'b0; bus.i_ctx_valid = 1'b1;
        repeat (3) begin
            bus.i_ctx_data = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        bus.i_ctx_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (bus.o_qea_state_ena !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_init_reached", bus.o_qea_state_ena, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ena", bus.o_qea_state_ena, 1'b0);
        chk("rst_mid_wea", bus.o_qea_state_wea, 1'b0);
        chk("rst_mid_ctx_en", bus.o_qea_ctx_en, 1'b0);
        chk("rst_mid_busy", bus.o_busy, 1'b0);
        chk("rst_mid_cfg_ready", bus.o_cfg_ready, 1'b1);
        chk("rst_mid_count", bus.o_cycle_count, 32'd0);
        rst = 1'b0;
        ena0 = ena_cnt; start_cnt = 0;
        repeat (30) @(negedge clk);
        chk("rst_mid_no_writes", ena_cnt, ena0);
        chk("rst_mid_no_start", start_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
